multi_pulse_led: RTL and testbench
==================================

MULTI_PULSE_LED -- requirements
Module: multi_pulse_led

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent LED outputs.
REQ-002 SHALL have parameter CNT_W, default 29, width of period counter and duty registers.
REQ-003 SHALL have parameter PERIOD, default 500000, PWM period in clk cycles.
REQ-004 SHALL have parameter STEP, default 20000, duty increment per period.
REQ-005 SHALL accept parameters only with PERIOD < 2^CNT_W, 0 < STEP <= PERIOD, and (CHANNELS-1)*STEP <= PERIOD.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 rst  input  1  reset; asynchronous and active-high.
REQ-008 en  input  1  run enable; low freezes all sequencing.
REQ-009 mode  input  2  requested mode: 0 BREATHE, 1 SAW, 2 FREEZE, 3 OFF.
REQ-010 led  output  CHANNELS  registered PWM outputs, bit i = channel i.

Function
REQ-011 Counter cnt SHALL count 0..PERIOD-1 and wrap to 0 when en=1; the cycle with cnt==PERIOD-1 and en=1 is the "boundary".
REQ-012 Each channel SHALL hold duty register ccr[i] (CNT_W bits) and direction bit dir[i].
REQ-013 Effective duty SHALL be eff[i] = ccr[i] when dir[i]=0, PERIOD-ccr[i] when dir[i]=1.
REQ-014 led[i] SHALL be registered as (cnt < eff[i]) from the current cnt; one cycle latency from cnt to led.
REQ-015 mode SHALL be sampled into mode_q only at a boundary; mode_q takes effect from the next cycle.
REQ-016 BREATHE at boundary: next=ccr[i]+STEP; if next > PERIOD then ccr[i]=0 and dir[i] toggles, else ccr[i]=next.
REQ-017 SAW at boundary: same increment, but on overflow ccr[i]=0 and dir[i] is held 0.
REQ-018 Entering SAW at a boundary SHALL clear all dir bits in that same update.
REQ-019 FREEZE: ccr and dir SHALL hold; PWM continues at held duty.
REQ-020 OFF: all led SHALL be 0; cnt keeps running; ccr and dir hold.
REQ-021 en=0: cnt, ccr, dir and mode_q SHALL hold; led SHALL be 0 from the next cycle; no boundary occurs.
REQ-022 Deasserting en SHALL resume from the held cnt with no restart of the period.
REQ-023 Increment arithmetic SHALL be evaluated one bit wider than CNT_W so next never wraps silently.
REQ-024 eff[i]=0 SHALL give led[i] constantly 0; eff[i]=PERIOD SHALL give led[i] constantly 1 while running.

Reset
REQ-025 While rst=1: cnt=0, ccr[i]=i*STEP, dir[i]=0, mode_q=BREATHE, led=0, and, when present, tick=0, wrap=0.
REQ-026 rst asserted mid-period SHALL abandon the period; the first cycle after release starts at cnt=0.

Configuration
REQ-027 Macro MULTI_PULSE_LED_TICK_EN SHALL control the status outputs.
REQ-028 With MULTI_PULSE_LED_TICK_EN defined: output tick (1 bit) SHALL pulse for 1 cycle, registered, in the cycle after each boundary.
REQ-029 With MULTI_PULSE_LED_TICK_EN defined: output wrap (CHANNELS bits) SHALL pulse bit i for 1 cycle, aligned with tick, when ccr[i] overflowed to 0.
REQ-030 Without the macro, tick and wrap ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (CHANNELS=4, CNT_W=8, PERIOD=10, STEP=2)
REQ-031 Release rst, en=1, mode=0 -> period 1: led[0] never high; led[1] high 2 of 10 cycles; led[2] high 4 of 10 cycles; led[3] high 6 of 10 cycles.
REQ-032 Run channel 0 in BREATHE for 12 periods -> high-cycle counts 0,2,4,6,8,10,10,8,6,4,2,0; with TICK_EN, wrap[0] pulses after period 6.
REQ-033 mode=1 held from reset -> channel 0 counts 0,2,4,6,8,10,0,2...; dir[0] stays 0.
REQ-034 Drop en for 7 cycles at cnt=5 -> led=0 during the gap; the period resumes at cnt=5 and the boundary occurs 4 cycles after re-enable.
REQ-035 Request mode=3 mid-period, then mode=2 -> led goes to 0 only after the next boundary; under FREEZE the duty is repeated unchanged for 3 periods.
REQ-036 Assert rst for 1 cycle at cnt=7 during period 4 -> all outputs 0 at once; afterwards the REQ-031 pattern restarts.

Source files
------------

// File: rtl/multi_pulse_led.sv
// Multi-channel breathing/sawtooth PWM LED driver with per-period duty stepping.
// Define MULTI_PULSE_LED_TICK_EN to add the tick/wrap status outputs.
module multi_pulse_led #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 29,
  parameter int PERIOD   = 500000,
  parameter int STEP     = 20000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] led
`ifdef MULTI_PULSE_LED_TICK_EN
  ,
  output logic                tick,
  output logic [CHANNELS-1:0] wrap
`endif
);

  typedef enum logic [1:0] {
    M_BREATHE = 2'd0,
    M_SAW     = 2'd1,
    M_FREEZE  = 2'd2,
    M_OFF     = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LP_PERIOD = CNT_W'(PERIOD);
  localparam logic [CNT_W:0]   LP_PER_W  = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   LP_STEP_W = (CNT_W+1)'(STEP);

  logic [CNT_W-1:0]    r_cnt;
  mode_e               r_mode_q;
  logic [CNT_W-1:0]    r_ccr [CHANNELS];
  logic [CHANNELS-1:0] r_dir;
  logic [CHANNELS-1:0] r_led;

  logic                w_bnd;
  logic                w_grow;
  mode_e               w_mode_in;
  logic [CNT_W-1:0]    w_eff    [CHANNELS];
  logic [CNT_W:0]      w_next   [CHANNELS];
  logic [CNT_W-1:0]    w_ccr_nx [CHANNELS];
  logic [CHANNELS-1:0] w_dir_nx;
  logic [CHANNELS-1:0] w_ovf;

  always_comb begin
    w_bnd     = en && (r_cnt == LP_LAST);
    w_mode_in = mode_e'(mode);
    w_grow    = (w_mode_in == M_BREATHE) || (w_mode_in == M_SAW);
    for (int i = 0; i < CHANNELS; i++) begin
      w_eff[i]    = r_dir[i] ? (LP_PERIOD - r_ccr[i]) : r_ccr[i];
      // One bit wider so a step past PERIOD is seen, not wrapped
      w_next[i]   = {1'b0, r_ccr[i]} + LP_STEP_W;
      w_ovf[i]    = w_next[i] > LP_PER_W;
      w_ccr_nx[i] = r_ccr[i];
      w_dir_nx[i] = r_dir[i];
      unique case (1'b1)
        (w_mode_in == M_BREATHE): begin
          if (w_ovf[i]) begin
            w_ccr_nx[i] = '0;
            w_dir_nx[i] = ~r_dir[i];
          end else begin
            w_ccr_nx[i] = w_next[i][CNT_W-1:0];
          end
        end
        (w_mode_in == M_SAW): begin
          w_ccr_nx[i] = w_ovf[i] ? '0 : w_next[i][CNT_W-1:0];
          w_dir_nx[i] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mode_q <= M_BREATHE;
      r_dir    <= '0;
      r_led    <= '0;
      for (int i = 0; i < CHANNELS; i++)
        r_ccr[i] <= CNT_W'(i * STEP);
    end else begin
      if (en)
        r_cnt <= w_bnd ? '0 : r_cnt + 1'b1;
      if (w_bnd) begin
        r_mode_q <= w_mode_in;
        r_dir    <= w_dir_nx;
        for (int i = 0; i < CHANNELS; i++)
          r_ccr[i] <= w_ccr_nx[i];
      end
      for (int i = 0; i < CHANNELS; i++)
        r_led[i] <= en && (r_mode_q != M_OFF) && (r_cnt < w_eff[i]);
    end
  end

  assign led = r_led;

`ifdef MULTI_PULSE_LED_TICK_EN
  logic                r_tick;
  logic [CHANNELS-1:0] r_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= 1'b0;
      r_wrap <= '0;
    end else begin
      r_tick <= w_bnd;
      r_wrap <= (w_bnd && w_grow) ? w_ovf : '0;
    end
  end

  assign tick = r_tick;
  assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_multi_pulse_led.sv
// Bench for multi_pulse_led: per-cycle model compare plus literal
// per-period high-count checks (CHANNELS=4, CNT_W=8, PERIOD=10, STEP=2).
module tb_multi_pulse_led;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int P  = 10;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [CH-1:0] led;
`ifdef MULTI_PULSE_LED_TICK_EN
  logic          tick;
  logic [CH-1:0] wrap;
`endif

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;
  int hc [CH];

  multi_pulse_led #(
    .CHANNELS(CH), .CNT_W(CW), .PERIOD(P), .STEP(S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .led (led)
`ifdef MULTI_PULSE_LED_TICK_EN
    ,
    .tick(tick),
    .wrap(wrap)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: integer duty/direction per channel
  int            m_cnt;
  int            m_mq;
  int            m_ccr [CH];
  bit            m_dir [CH];
  logic [CH-1:0] m_led;
  logic          m_tick;
  logic [CH-1:0] m_wrap;

  function automatic int eff(int c);
    return m_dir[c] ? P - m_ccr[c] : m_ccr[c];
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cnt = 0;
      m_mq = 0;
      for (int i = 0; i < CH; i++) begin
        m_ccr[i] = i * S;
        m_dir[i] = 1'b0;
      end
      m_led = '0;
      m_tick = 1'b0;
      m_wrap = '0;
    end else begin
      for (int i = 0; i < CH; i++)
        m_led[i] = en && (m_mq != 3) && (m_cnt < eff(i));
      m_tick = 1'b0;
      m_wrap = '0;
      if (en && m_cnt == P - 1) begin
        m_tick = 1'b1;
        m_mq = int'(mode);
        m_cnt = 0;
        if (mode <= 2'd1) begin
          for (int i = 0; i < CH; i++) begin
            if (m_ccr[i] + S > P) begin
              m_ccr[i] = 0;
              m_wrap[i] = 1'b1;
              m_dir[i] = (mode == 2'd0) ? !m_dir[i] : 1'b0;
            end else begin
              m_ccr[i] = m_ccr[i] + S;
              if (mode == 2'd1) m_dir[i] = 1'b0;
            end
          end
        end
      end else if (en) begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (cmp_on) begin
      chk("model_led", 32'(led), 32'(m_led));
`ifdef MULTI_PULSE_LED_TICK_EN
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
`endif
    end
  end

  task automatic do_reset(input logic [1:0] md);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    mode = md;
    #1 chk("reset_led", 32'(led), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < CH; i++) hc[i] += int'(led[i]);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < CH; i++) hc[i] = 0;
  endtask

  task automatic chk_all(string nm, int a, int b, int c, int d);
    chk({nm, "_ch0"}, 32'(hc[0]), 32'(a));
    chk({nm, "_ch1"}, 32'(hc[1]), 32'(b));
    chk({nm, "_ch2"}, 32'(hc[2]), 32'(c));
    chk({nm, "_ch3"}, 32'(hc[3]), 32'(d));
  endtask

  int breathe0 [12] = '{0, 2, 4, 6, 8, 10, 10, 8, 6, 4, 2, 0};
  int saw0     [8]  = '{0, 2, 4, 6, 8, 10, 0, 2};

  initial begin
    rst = 1'b0;
    en = 1'b0;
    mode = 2'd0;

    // Breathe from reset: first period pattern and channel 0 triangle
    do_reset(2'd0);
    cmp_on = 1'b1;
    for (int p = 0; p < 12; p++) begin
      clr();
      sample(P);
      if (p == 0) chk_all("first_period", 0, 2, 4, 6);
      else chk("breathe_ch0", 32'(hc[0]), 32'(breathe0[p]));
    end

    // Sawtooth from reset
    do_reset(2'd1);
    for (int p = 0; p < 8; p++) begin
      clr();
      sample(P);
      chk("saw_ch0", 32'(hc[0]), 32'(saw0[p]));
    end

    // Enable gap of 7 cycles at cnt=5
    do_reset(2'd0);
    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #1 chk("gap_led", 32'(led), 32'd0);
    end
    en = 1'b1;
    clr();
    sample(5);
    chk_all("resume_tail", 0, 0, 0, 1);
    clr();
    sample(P);
    chk_all("resume_next", 2, 4, 6, 8);

    // OFF requested mid-period, then FREEZE
    do_reset(2'd0);
    sample(P);
    clr();
    sample(3);
    mode = 2'd3;
    sample(7);
    chk_all("off_pending", 2, 4, 6, 8);
    clr();
    sample(3);
    mode = 2'd2;
    sample(7);
    chk_all("off_active", 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      clr();
      sample(P);
      chk_all("freeze", 2, 4, 6, 8);
    end

    // Asynchronous reset at cnt=7 of period 4
    do_reset(2'd0);
    repeat (3 * P + 7) @(negedge clk);
    rst = 1'b1;
    #1 chk("async_rst_led", 32'(led), 32'd0);
`ifdef MULTI_PULSE_LED_TICK_EN
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_wrap", 32'(wrap), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    clr();
    sample(P);
    chk_all("after_rst", 0, 2, 4, 6);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
